// File: rtl/if_fetch_pkg.sv
// Shared core defines for the fetch front end: widths, reset defaults and the
// buffered fetch entry format.
package if_fetch_pkg;

    localparam int unsigned INST_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched {pc, inst} pairs; flush empties it and
// takes priority over push and pop.
module fetch_buf
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t [1:0] mem_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    // When full, a simultaneous pop frees the slot the push lands in.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one ROM read per cycle under a credit limit
// so the two-entry buffer cannot overflow; branches flush and redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [31:0]       rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              branch_i,
    input  logic [31:0]       branch_target_i,
    input  logic              id_ready_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_o
);

    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_data;
    logic         pop, push, issue;
    logic [2:0]   credit;

    assign inst_valid_o = ~rst & (count != 2'd0);
    assign pop          = inst_valid_o & id_ready_i & ~branch_i;
    assign push         = inflight_q & ~branch_i & ~rst;

    // Occupancy once this cycle settles, counting the read still in the ROM.
    assign credit = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = ~rst & ~branch_i & (credit < 3'd2);

    assign rom_ce_o   = issue;
    assign rom_addr_o = rst ? RESET_PC : pc_q;
    assign inst_o     = inst_valid_o ? head.inst : NOP_INST;
    assign pc_o       = inst_valid_o ? head.pc : 32'h0;

    assign push_data.pc   = inflight_pc_q;
    assign push_data.inst = rom_inst_i;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (branch_i) begin
            pc_d = align_pc(branch_target_i);
        end else if (issue) begin
            pc_d          = pc_q + PC_INC;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (branch_i),
        .count_o     (count),
        .head_o      (head)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Randomised and directed checks of if_fetch against a queue-based
// transaction model of the fetch stage; ROM word i holds value i.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i = 32'h0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        id_ready_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    logic        rst2 = 1'b1;
    logic        ce2;
    logic [31:0] addr2;
    logic [31:0] rom2 = 32'h0;
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = 32'h0;
    logic        rdy2 = 1'b1;
    logic        vld2;
    logic [31:0] inst2, pc2;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    logic [31:0] nxt_rom = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_inst_i(rom_inst_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .id_ready_i(id_ready_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst2), .rom_ce_o(ce2), .rom_addr_o(addr2),
        .rom_inst_i(rom2), .branch_i(br2), .branch_target_i(tgt2),
        .id_ready_i(rdy2), .inst_valid_o(vld2), .inst_o(inst2), .pc_o(pc2)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic rdy);
        logic e_valid, e_pop, e_issue;
        @(negedge clk);
        rom_inst_i      = nxt_rom;
        rst             = r;
        branch_i        = b;
        branch_target_i = t;
        id_ready_i      = rdy;
        #1;
        e_valid = !r && (m_q.size() != 0);
        e_pop   = e_valid && rdy && !b;
        e_issue = !r && !b && ((int'(m_q.size()) + int'(m_infl) - int'(e_pop)) < 2);
        chk("rom_ce", {31'b0, rom_ce_o}, {31'b0, e_issue});
        chk("rom_addr", rom_addr_o, r ? 32'h0 : m_pc);
        chk("valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
        chk("inst", inst_o, e_valid ? m_q[0].inst : NOP);
        chk("pc", pc_o, e_valid ? m_q[0].pc : 32'h0);
        nxt_rom = rom_ce_o ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;
        if (r) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_infl = 1'b0;
        end else if (b) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = {t[31:2], 2'b00};
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back('{pc: m_infl_pc, inst: rom_word(m_infl_pc)});
            if (m_q.size() > 2) begin
                chk("model_depth", m_q.size(), 2);
            end
            if (e_issue) begin
                m_infl    = 1'b1;
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    initial begin
        // Wrap-around from a high reset PC on the second instance.
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap0", addr2, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap1", addr2, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap2", addr2, 32'h0000_0000);

        // Reset release and first-instruction latency, then a decode stall.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, NOP);
        step(0, 0, 0, 1);
        chk("c0_valid", {31'b0, inst_valid_o}, 32'h0);
        step(0, 0, 0, 1);
        chk("c1_valid", {31'b0, inst_valid_o}, 32'h0);
        step(0, 0, 0, 0);
        chk("c2_valid", {31'b0, inst_valid_o}, 32'h1);
        chk("c2_pc", pc_o, 32'h0);
        chk("c2_inst", inst_o, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("stall_ce", {31'b0, rom_ce_o}, 32'h0);
        chk("stall_pc", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("drain_pc", pc_o, 32'(i * 4));
        end

        // Redirect while the buffer is full.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 0);
        step(0, 0, 0, 1);
        chk("br_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("br_addr", rom_addr_o, 32'h100);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("br_pc", pc_o, 32'h100);

        // Redirect coinciding with pop and push in steady streaming.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 1, 32'h0000_0040, 1);
        step(0, 0, 0, 1);
        chk("brpp_valid", {31'b0, inst_valid_o}, 32'h0);

        // Wrap on the main instance, then a one-cycle mid-stream reset.
        step(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("mrst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("mrst_addr", rom_addr_o, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic        r, b, rdy;
            logic [31:0] t;
            r   = ($urandom_range(0, 49) == 0);
            b   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, b, t, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the value driven on inst_o when no instruction is valid.
REQ-003 clk  in  1  single clock, rising-edge; all state updates on this edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rom_ce_o  out  1  ROM read enable; one fetch issued per cycle it is high.
REQ-006 rom_addr_o  out  32  byte address of the issued fetch.
REQ-007 rom_inst_i  in  32  ROM read data, valid exactly 1 cycle after a rom_ce_o=1 cycle.
REQ-008 branch_i  in  1  redirect request from execute stage.
REQ-009 branch_target_i  in  32  redirect address.
REQ-010 id_ready_i  in  1  decode stage accepts the head instruction this cycle.
REQ-011 inst_valid_o  out  1  inst_o and pc_o hold a valid instruction.
REQ-012 inst_o  out  32  head instruction.
REQ-013 pc_o  out  32  address of the head instruction.

Function
REQ-014 State: pc_q (next fetch address), inflight_q (1 bit, fetch pending in ROM), inflight_pc_q, 2-entry FIFO of {pc, inst} with count_q in 0..2.
REQ-015 Issue condition: not rst, not branch_i, and (count_q + inflight_q - pop) < 2, where pop = inst_valid_o & id_ready_i; rom_ce_o SHALL equal the issue condition.
REQ-016 rom_addr_o SHALL equal pc_q; on issue, pc_q <= pc_q + 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), inflight_q <= 1, inflight_pc_q <= pc_q; otherwise inflight_q <= 0.
REQ-017 When inflight_q=1 and branch_i=0, {inflight_pc_q, rom_inst_i} SHALL be pushed into the FIFO at the end of that cycle.
REQ-018 inst_valid_o = (count_q != 0); inst_o/pc_o SHALL be the head entry; when empty, inst_o = NOP_INST and pc_o = 0.
REQ-019 Pop when inst_valid_o & id_ready_i; simultaneous push and pop SHALL keep count_q unchanged and preserve order.
REQ-020 Credit rule (REQ-015) SHALL guarantee a push never occurs with count_q=2 and no pop; the FIFO never overflows.
REQ-021 Latency: fetch issued in cycle N appears on inst_o in cycle N+2 if FIFO was empty; sustained throughput 1 instruction/cycle while id_ready_i=1.
REQ-022 Redirect: branch_i=1 in cycle N SHALL clear FIFO (count_q <= 0), discard the inflight return, suppress issue and pop in N, set pc_q <= {branch_target_i[31:2], 2'b00}; fetch of target issues in N+1.
REQ-023 branch_i SHALL take priority over push, pop and issue when simultaneous.
REQ-024 id_ready_i=0 SHALL hold inst_o/pc_o stable while inst_valid_o=1.

Reset
REQ-025 While rst=1: pc_q <= RESET_PC, count_q <= 0, inflight_q <= 0; outputs rom_ce_o=0, rom_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP_INST, pc_o=0.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents and inflight fetch; first fetch at RESET_PC in the first cycle with rst=0.

Structure
REQ-027 RESET_PC default, NOP_INST, instruction width (32) and PC increment (4) SHALL live in the shared core defines package used by the pipeline.
REQ-028 The 2-entry FIFO SHALL be a sub-module named fetch_buf (push, pop, flush, count, head outputs).
REQ-029 Instantiated in core_top between the rom and the IF/ID consumer; no other clock domains.

Verification
REQ-030 Reset release, id_ready_i=1, ROM[i]=i -> rom_addr_o 0,4,8,... one per cycle; inst_valid_o first high 2 cycles after rst falls with pc_o=0, inst_o=0; then one new instruction per cycle.
REQ-031 id_ready_i=0 for 5 cycles after first valid -> count_q reaches 2, rom_ce_o=0, inst_o/pc_o frozen at pc 0; release -> pc_o 0,4,8 in order, no loss/duplication.
REQ-032 branch_i=1, target 32'h0000_0103 while FIFO full and fetch inflight -> next cycle inst_valid_o=0, rom_addr_o=32'h100; pc_o=32'h100 two cycles later; no stale pc appears.
REQ-033 branch_i=1 coincident with pop and push -> pop and push suppressed, FIFO empty next cycle.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> rom_addr_o FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-035 rst=1 for 1 cycle mid-stream -> inst_valid_o=0 next cycle, fetch restarts at RESET_PC.
